ddr3_ddl_cmd: RTL and testbench

- Command-layer responder for the DDR3 controller FSM's DDL request interface.
- Accepts ACT/RD/WR/PRE/REF/MRS/ZQCL requests and enforces minimum inter-command timing by withholding `ddl_rdy_o`.
- Drives registered DDR3 command/address pins.
- Owns the tREFI refresh timer and raises `ddl_ref_o` to request refresh scheduling.

---
 rtl/ddr3_ddl_cmd_pkg.sv | 29 ++
 rtl/ddr3_refresh_timer.sv | 36 +++
 rtl/ddr3_ddl_cmd.sv | 134 +++++++++++++
 tb/tb_ddr3_ddl_cmd.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ddl_cmd_pkg.sv
// rtl/ddr3_ddl_cmd_pkg.sv - DDR3 command codes and default timing for a 100 MHz controller clock
package ddr3_ddl_cmd_pkg;

    // Command codes are the raw {ras_n, cas_n, we_n} pin encoding
    localparam logic [2:0] CMD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFR = 3'b001;
    localparam logic [2:0] CMD_PREC = 3'b010;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOOP = 3'b111;

    localparam int DEF_CYC_RCD  = 2;
    localparam int DEF_CYC_RP   = 2;
    localparam int DEF_CYC_RFC  = 11;
    localparam int DEF_CYC_CCD  = 4;
    localparam int DEF_CYC_WTR  = 13;
    localparam int DEF_CYC_RDAP = 6;
    localparam int DEF_CYC_WRAP = 13;
    localparam int DEF_CYC_MRD  = 12;
    localparam int DEF_CYC_ZQ   = 512;
    localparam int DEF_CYC_REFI = 780;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// rtl/ddr3_refresh_timer.sv - tREFI interval counter with a single refresh-pending flag
module ddr3_refresh_timer #(
    parameter int CYC_REFI = 780
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic ref_ack,
    output logic ref_due
);

    localparam int CNT_W = $clog2(CYC_REFI);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYC_REFI - 1);

    logic [CNT_W-1:0] cnt;

    // An ack coinciding with expiry wins: the fresh interval has already started
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt     <= RELOAD;
            ref_due <= 1'b0;
        end else begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
            if (ref_ack) begin
                ref_due <= 1'b0;
            end else if (cnt == '0) begin
                ref_due <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_ddl_cmd.sv
// rtl/ddr3_ddl_cmd.sv - DDL command responder: inter-command spacing, registered DFI pins, refresh request
module ddr3_ddl_cmd
    import ddr3_ddl_cmd_pkg::*;
#(
    parameter int DDR_ROW_BITS = 13,
    parameter int CYC_RCD      = DEF_CYC_RCD,
    parameter int CYC_RP       = DEF_CYC_RP,
    parameter int CYC_RFC      = DEF_CYC_RFC,
    parameter int CYC_CCD      = DEF_CYC_CCD,
    parameter int CYC_WTR      = DEF_CYC_WTR,
    parameter int CYC_RDAP     = DEF_CYC_RDAP,
    parameter int CYC_WRAP     = DEF_CYC_WRAP,
    parameter int CYC_MRD      = DEF_CYC_MRD,
    parameter int CYC_ZQ       = DEF_CYC_ZQ,
    parameter int CYC_REFI     = DEF_CYC_REFI
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ctl_run_i,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic                    dfi_cs_n_o,
    output logic                    dfi_ras_n_o,
    output logic                    dfi_cas_n_o,
    output logic                    dfi_we_n_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o
);

    localparam int CYC_MAX = max_int(
        max_int(max_int(CYC_RCD, CYC_RP), max_int(CYC_RFC, CYC_CCD)),
        max_int(max_int(CYC_WTR, CYC_RDAP), max_int(max_int(CYC_WRAP, CYC_MRD), CYC_ZQ)));
    localparam int WAIT_W = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic ST_READY = 1'b0;
    localparam logic ST_WAIT  = 1'b1;

    logic              state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wtr_cnt;
    logic [WAIT_W-1:0] wait_load;
    int                wait_n;
    logic              auto_pre;
    logic              wtr_block;
    logic              accept;

    // Bit 10 only means auto-precharge when the burst is not continuing
    assign auto_pre  = ddl_adr_i[10] && !ddl_seq_i;
    assign wtr_block = (wtr_cnt != '0) && (ddl_cmd_i == CMD_READ);
    assign ddl_rdy_o = (state == ST_READY) && !wtr_block;
    assign accept    = ddl_req_i && ddl_rdy_o && (ddl_cmd_i != CMD_NOOP);

    always_comb begin
        wait_n = 1;
        case (ddl_cmd_i)
            CMD_ACTV: wait_n = CYC_RCD;
            CMD_PREC: wait_n = CYC_RP;
            CMD_REFR: wait_n = CYC_RFC;
            CMD_MODE: wait_n = CYC_MRD;
            CMD_ZQCL: wait_n = CYC_ZQ;
            CMD_READ: wait_n = auto_pre ? CYC_RDAP : CYC_CCD;
            CMD_WRIT: wait_n = auto_pre ? CYC_WRAP : CYC_CCD;
            default:  wait_n = 1;
        endcase
        wait_load = WAIT_W'(wait_n - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_READY;
            wait_cnt <= '0;
            wtr_cnt  <= '0;
        end else begin
            if (accept && ddl_cmd_i == CMD_WRIT && !ddl_adr_i[10]) begin
                wtr_cnt <= WAIT_W'(CYC_WTR - 1);
            end else if (wtr_cnt != '0) begin
                wtr_cnt <= wtr_cnt - WAIT_W'(1);
            end

            case (state)
                ST_READY: begin
                    if (accept && wait_load != '0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= wait_load;
                    end
                end
                default: begin
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state    <= ST_READY;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
            endcase
        end
    end

    // Bank/address hold between commands so the bus only toggles on issue
    always_ff @(posedge clock) begin
        if (reset) begin
            dfi_cs_n_o  <= 1'b1;
            dfi_ras_n_o <= 1'b1;
            dfi_cas_n_o <= 1'b1;
            dfi_we_n_o  <= 1'b1;
            dfi_ba_o    <= '0;
            dfi_adr_o   <= '0;
        end else if (accept) begin
            dfi_cs_n_o                              <= 1'b0;
            {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= ddl_cmd_i;
            dfi_ba_o                                <= ddl_ba_i;
            dfi_adr_o                               <= ddl_adr_i;
        end else begin
            dfi_cs_n_o                              <= 1'b1;
            {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= CMD_NOOP;
        end
    end

    ddr3_refresh_timer #(
        .CYC_REFI(CYC_REFI)
    ) u_refresh_timer (
        .clock   (clock),
        .reset   (reset),
        .run     (ctl_run_i),
        .ref_ack (accept && ddl_cmd_i == CMD_REFR),
        .ref_due (ddl_ref_o)
    );

endmodule

// File: tb/tb_ddr3_ddl_cmd.sv
// tb/tb_ddr3_ddl_cmd.sv - directed bench for ddr3_ddl_cmd with a pin scoreboard
module tb_ddr3_ddl_cmd;
    import ddr3_ddl_cmd_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctl_run_i;
    logic        ddl_req_i;
    logic        ddl_seq_i;
    logic        ddl_rdy_o;
    logic        ddl_ref_o;
    logic [2:0]  ddl_cmd_i;
    logic [2:0]  ddl_ba_i;
    logic [12:0] ddl_adr_i;
    logic        dfi_cs_n_o;
    logic        dfi_ras_n_o;
    logic        dfi_cas_n_o;
    logic        dfi_we_n_o;
    logic [2:0]  dfi_ba_o;
    logic [12:0] dfi_adr_o;

    ddr3_ddl_cmd dut (
        .clock       (clock),
        .reset       (reset),
        .ctl_run_i   (ctl_run_i),
        .ddl_req_i   (ddl_req_i),
        .ddl_seq_i   (ddl_seq_i),
        .ddl_rdy_o   (ddl_rdy_o),
        .ddl_ref_o   (ddl_ref_o),
        .ddl_cmd_i   (ddl_cmd_i),
        .ddl_ba_i    (ddl_ba_i),
        .ddl_adr_i   (ddl_adr_i),
        .dfi_cs_n_o  (dfi_cs_n_o),
        .dfi_ras_n_o (dfi_ras_n_o),
        .dfi_cas_n_o (dfi_cas_n_o),
        .dfi_we_n_o  (dfi_we_n_o),
        .dfi_ba_o    (dfi_ba_o),
        .dfi_adr_o   (dfi_adr_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [2:0]  ba;
        logic [12:0] adr;
    } pin_exp_t;

    pin_exp_t sb[$];
    pin_exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [2:0] cmd, input logic [2:0] ba,
                         input logic [12:0] adr, input logic seq);
        ddl_req_i = req;
        ddl_cmd_i = cmd;
        ddl_ba_i  = ba;
        ddl_adr_i = adr;
        ddl_seq_i = seq;
    endtask

    // The command currently driven is expected on the pins one cycle later
    task automatic expect_accept();
        sb.push_back('{cyc + 1, ddl_cmd_i, ddl_ba_i, ddl_adr_i});
    endtask

    task automatic step(input string tag, input logic exp_rdy);
        #2;
        check(tag, 32'(ddl_rdy_o), 32'(exp_rdy));
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!dfi_cs_n_o) begin
            if (sb.size() == 0) begin
                check("pin_unexpected_cs", 32'(dfi_cs_n_o), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("pin_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("pin_bits", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_ba_o, dfi_adr_o}),
                      32'({mon_e.cmd, mon_e.ba, mon_e.adr}));
            end
        end else begin
            check("pin_idle_cmd", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'(CMD_NOOP));
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                check("pin_missing_cs", 32'(dfi_cs_n_o), 32'd0);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ctl_run_i = 1'b0;
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_rdy", 32'(ddl_rdy_o), 32'd1);
        check("rst_ref", 32'(ddl_ref_o), 32'd0);
        check("rst_cs_n", 32'(dfi_cs_n_o), 32'd1);
        check("rst_cmd", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'd7);
        check("rst_ba_adr", 32'({dfi_ba_o, dfi_adr_o}), 32'd0);
        reset = 1'b0;
        step("post_rst_rdy", 1'b1);
        check("post_rst_ba_adr", 32'({dfi_ba_o, dfi_adr_o}), 32'd0);
        check("post_rst_ref", 32'(ddl_ref_o), 32'd0);
        while (cyc < 10) step("idle_rdy", 1'b1);

        // ACT then WR held on the request line
        drive(1'b1, CMD_ACTV, 3'd3, 13'h0123, 1'b0);
        expect_accept();
        step("act_acc", 1'b1);
        drive(1'b1, CMD_WRIT, 3'd3, 13'h0008, 1'b0);
        step("act_rcd", 1'b0);
        expect_accept();
        step("wr_acc", 1'b1);

        // READ held back by the write-to-read window
        drive(1'b1, CMD_READ, 3'd3, 13'h0010, 1'b0);
        for (int i = 1; i <= 12; i++) step("wtr_hold", 1'b0);
        expect_accept();
        step("rd_acc_wtr", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        repeat (3) step("rd_ccd", 1'b0);

        // PRE is not subject to the write-to-read window
        drive(1'b1, CMD_WRIT, 3'd5, 13'h0020, 1'b0);
        expect_accept();
        step("wr2_acc", 1'b1);
        drive(1'b1, CMD_PREC, 3'd5, 13'h0400, 1'b0);
        repeat (3) step("wr2_ccd", 1'b0);
        expect_accept();
        step("pre_acc", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        step("pre_rp", 1'b0);
        drive(1'b1, CMD_READ, 3'd1, 13'h0040, 1'b0);
        step("wtr_rd_blocked", 1'b0);
        drive(1'b0, CMD_ACTV, 3'd1, 13'h0040, 1'b0);
        step("wtr_act_rdy", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        repeat (10) step("wtr_noop_rdy", 1'b1);

        // Burst-continuation READs ignore bit 10
        drive(1'b1, CMD_READ, 3'd1, 13'h0400, 1'b1);
        expect_accept();
        step("seq_rd1", 1'b1);
        repeat (3) step("seq_ccd", 1'b0);
        expect_accept();
        step("seq_rd2", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        repeat (3) step("seq2_ccd", 1'b0);

        // Auto-precharge WR then ACT
        drive(1'b1, CMD_WRIT, 3'd2, 13'h0400, 1'b0);
        expect_accept();
        step("wrap_acc", 1'b1);
        drive(1'b1, CMD_ACTV, 3'd2, 13'h1abc, 1'b0);
        repeat (12) step("wrap_hold", 1'b0);
        expect_accept();
        step("act_after_wrap", 1'b1);
        drive(1'b1, CMD_READ, 3'd2, 13'h0404, 1'b0);
        step("rcd2", 1'b0);
        expect_accept();
        step("rdap_acc", 1'b1);
        drive(1'b1, CMD_NOOP, 3'd6, 13'h1fff, 1'b0);
        repeat (5) step("rdap_hold", 1'b0);
        step("noop_absorb", 1'b1);
        step("noop_absorb2", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);

        // Refresh interval
        ctl_run_i = 1'b1;
        repeat (779) begin
            @(posedge clock);
            #1;
        end
        check("ref_before", 32'(ddl_ref_o), 32'd0);
        @(posedge clock);
        #1;
        check("ref_rise", 32'(ddl_ref_o), 32'd1);
        repeat (3) begin
            @(posedge clock);
            #1;
            check("ref_hold", 32'(ddl_ref_o), 32'd1);
        end
        drive(1'b1, CMD_REFR, 3'd0, 13'h0, 1'b0);
        expect_accept();
        step("ref_acc", 1'b1);
        check("ref_clear", 32'(ddl_ref_o), 32'd0);
        drive(1'b1, CMD_MODE, 3'd2, 13'h0a55, 1'b0);
        repeat (10) step("rfc_hold", 1'b0);
        expect_accept();
        step("mrs_acc", 1'b1);

        // Reset aborts a ZQCL wait
        drive(1'b1, CMD_ZQCL, 3'd0, 13'h0400, 1'b0);
        repeat (11) step("mrd_hold", 1'b0);
        expect_accept();
        step("zq_acc", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        repeat (99) step("zq_hold", 1'b0);
        reset = 1'b1;
        step("zq_hold_rst", 1'b0);
        reset = 1'b0;
        #2;
        check("zq_rst_rdy", 32'(ddl_rdy_o), 32'd1);
        check("zq_rst_cs_n", 32'(dfi_cs_n_o), 32'd1);
        check("zq_rst_cmd", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'd7);
        check("zq_rst_ba_adr", 32'({dfi_ba_o, dfi_adr_o}), 32'd0);
        check("zq_rst_ref", 32'(ddl_ref_o), 32'd0);
        @(posedge clock);
        #1;
        drive(1'b1, CMD_ACTV, 3'd4, 13'h0777, 1'b0);
        expect_accept();
        step("post_rst_act", 1'b1);
        drive(1'b0, CMD_NOOP, 3'd0, 13'h0, 1'b0);
        step("post_rst_rcd", 1'b0);
        step("final_idle", 1'b1);
        step("final_idle2", 1'b1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
